// File: rtl/mips_boot_loader.sv
// mips_boot_loader: byte-serial program loader for pipe_MIPS32.
// Receives a length-prefixed image (N[15:8], N[7:0], then N big-endian
// 32-bit words) over a valid/ready byte stream. It writes the words to
// instruction/data memory from word address 0 upward, then releases the core.
//
// Optional feature: define MIPS_BOOT_CHECKSUM_EN to require a trailing
// XOR checksum byte over all payload bytes before the core is released.
//
// Ports:
//   clk1        system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    source presents a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   mem_we      one-cycle memory write strobe
//   mem_addr    word address of the write
//   mem_wdata   word to write
//   core_run    core released (image fully written)
//   load_done   image fully written
//   err         load aborted (oversize header or checksum mismatch)
//   word_count  words written so far
module mips_boot_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WR,
`ifdef MIPS_BOOT_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  // State entered once the payload (possibly empty) is complete.
`ifdef MIPS_BOOT_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_run_q, core_run_d;
  logic              load_done_q, load_done_d;
  logic              err_q, err_d;
`ifdef MIPS_BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept;
  logic [15:0]       n_full;
  logic [ADDR_W:0]   wc_inc;

  always_comb begin
    accept       = in_valid && in_ready_q;
    n_full       = {n_q[15:8], in_data};
    wc_inc       = word_count_q + 1'b1;
    state_d      = state_q;
    n_d          = n_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef MIPS_BOOT_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      HDR_HI: if (accept) begin
        n_d[15:8] = in_data;
        state_d   = HDR_LO;
      end
      HDR_LO: if (accept) begin
        n_d[7:0] = in_data;
        if (n_full == 16'd0)
          state_d = END_STATE;
        else if (32'(n_full) > MEM_DEPTH)
          state_d = ERROR;
        else begin
          state_d    = DATA;
          byte_idx_d = 2'd0;
        end
      end
      DATA: if (accept) begin
        asm_d      = {asm_q[15:0], in_data};
        byte_idx_d = byte_idx_q + 2'd1;
`ifdef MIPS_BOOT_CHECKSUM_EN
        csum_d     = csum_q ^ in_data;
`endif
        // Registered write outputs are loaded on the 4th byte so the
        // strobe appears during the single WR cycle.
        if (byte_idx_q == 2'd3) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_count_q[ADDR_W-1:0];
          mem_wdata_d = {asm_q, in_data};
        end
      end
      WR: begin
        word_count_d = wc_inc;
        state_d      = (32'(wc_inc) == 32'(n_q)) ? END_STATE : DATA;
      end
`ifdef MIPS_BOOT_CHECKSUM_EN
      CSUM: if (accept) begin
        state_d = (in_data == csum_q) ? DONE : ERROR;
      end
`endif
      default: ;  // DONE and ERROR are sticky until rst
    endcase

    // Status outputs are registered from the next state.
    in_ready_d  = !(state_d == WR || state_d == DONE || state_d == ERROR);
    core_run_d  = (state_d == DONE);
    load_done_d = (state_d == DONE);
    err_d       = (state_d == ERROR);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= HDR_HI;
      n_q          <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_run_q   <= 1'b0;
      load_done_q  <= 1'b0;
      err_q        <= 1'b0;
`ifdef MIPS_BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_run_q   <= core_run_d;
      load_done_q  <= load_done_d;
      err_q        <= err_d;
`ifdef MIPS_BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_run   = core_run_q;
  assign load_done  = load_done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Testbench for mips_boot_loader. Honours MIPS_BOOT_CHECKSUM_EN when defined.
module tb_mips_boot_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              load_done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  mips_boot_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(1024)) dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_run(core_run), .load_done(load_done),
    .err(err), .word_count(word_count)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] image [9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
                             32'h0ce77800, 32'h0ce77800, 32'h00222000,
                             32'h0ce77800, 32'h00832800, 32'hfc000000};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor, release-latency tracker and in_ready watchdog.
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  int cyc = 0;
  int last_we_cyc = -1;
  int run_cyc = -1;
  int ready_viol = 0;

  always @(negedge clk1) begin
    cyc++;
    if (!rst) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        last_we_cyc = cyc;
      end
      if (core_run && run_cyc < 0) run_cyc = cyc;
      if (!in_ready && !mem_we && !load_done && !err) ready_viol++;
    end
  end

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    last_we_cyc = -1;
    run_cyc = -1;
    ready_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit done = 1'b0;
    int guard = 0;
    while (!done) begin
      @(negedge clk1);
      if (stall && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        done     = in_ready;
      end
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 32'(guard), 32'd0);
        done = 1'b1;
      end
    end
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int unsigned i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], stall);
  endtask

  task automatic load_image(input bit stall);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'h00, stall);
    send_byte(8'h09, stall);
    for (int unsigned i = 0; i < 9; i++) begin
      send_word(image[i], stall);
      x = x ^ image[i][31:24] ^ image[i][23:16] ^ image[i][15:8] ^ image[i][7:0];
    end
`ifdef MIPS_BOOT_CHECKSUM_EN
    send_byte(x, stall);
`endif
    repeat (3) @(negedge clk1);
  endtask

  task automatic check_full_load(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd9);
    for (int unsigned i = 0; i < 9 && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], image[i]);
    end
    chk({tag, "_wc"}, 32'(word_count), 32'd9);
    chk({tag, "_run"}, 32'(core_run), 32'd1);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_runlat"}, 32'(run_cyc - last_we_cyc), 32'd1);
    chk({tag, "_rdyviol"}, 32'(ready_viol), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_run"}, 32'(core_run), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Full image, back-to-back bytes
    load_image(1'b0);
    check_full_load("load");

    // Same image with random stalls
    do_reset();
    load_image(1'b1);
    check_full_load("stall");

    // Oversize header 0x0401
    do_reset();
    send_byte(8'h04, 1'b0);
    chk("big_err_b1", 32'(err), 32'd0);
    send_byte(8'h01, 1'b0);
    chk("big_err_b2", 32'(err), 32'd1);
    chk("big_rdy_b2", 32'(in_ready), 32'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk1);
      in_valid = 1'b1;
      in_data  = 8'(8'h28 + i);
    end
    @(negedge clk1);
    in_valid = 1'b0;
    chk("big_err", 32'(err), 32'd1);
    chk("big_rdy", 32'(in_ready), 32'd0);
    chk("big_run", 32'(core_run), 32'd0);
    chk("big_done", 32'(load_done), 32'd0);
    chk("big_nwr", 32'(wr_addr.size()), 32'd0);
    chk("big_wc", 32'(word_count), 32'd0);

    // Empty image N=0
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef MIPS_BOOT_CHECKSUM_EN
    chk("n0_done_pre", 32'(load_done), 32'd0);
    chk("n0_rdy_pre", 32'(in_ready), 32'd1);
    send_byte(8'h00, 1'b0);
`endif
    @(negedge clk1);
    chk("n0_done", 32'(load_done), 32'd1);
    chk("n0_run", 32'(core_run), 32'd1);
    chk("n0_err", 32'(err), 32'd0);
    chk("n0_nwr", 32'(wr_addr.size()), 32'd0);

    // Reset mid-load after 2 bytes of word 3, then a fresh load
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h09, 1'b0);
    for (int unsigned i = 0; i < 3; i++) send_word(image[i], 1'b0);
    send_byte(image[3][31:24], 1'b0);
    send_byte(image[3][23:16], 1'b0);
    @(negedge clk1);
    chk("mid_wc_pre", 32'(word_count), 32'd3);
    chk("mid_addr_pre", 32'(mem_addr), 32'd2);
    do_reset();
    check_reset_vals("mid");
    load_image(1'b0);
    check_full_load("reload");

`ifdef MIPS_BOOT_CHECKSUM_EN
    // Single word, good checksum 0x23
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h2801000a, 1'b0);
    send_byte(8'h23, 1'b0);
    @(negedge clk1);
    chk("cs_ok_done", 32'(load_done), 32'd1);
    chk("cs_ok_run", 32'(core_run), 32'd1);
    chk("cs_ok_err", 32'(err), 32'd0);
    chk("cs_ok_nwr", 32'(wr_addr.size()), 32'd1);

    // Same word, bad checksum 0x24
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_word(32'h2801000a, 1'b0);
    send_byte(8'h24, 1'b0);
    @(negedge clk1);
    chk("cs_bad_err", 32'(err), 32'd1);
    chk("cs_bad_run", 32'(core_run), 32'd0);
    chk("cs_bad_done", 32'(load_done), 32'd0);
    chk("cs_bad_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("cs_bad_addr", 32'(wr_addr[0]), 32'd0);
      chk("cs_bad_data", wr_data[0], 32'h2801000a);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound in case a wait never completes.
  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
